serial_add_rtl: RTL and testbench



---
 rtl/serial_add_if.sv | 20 ++
 rtl/serial_add_rtl.sv | 89 ++++++++
 tb/tb_serial_add_rtl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// Handshake: start is sampled only while busy=0. It is accepted in IDLE or in the one-cycle done
// slot. done pulses for one cycle with sum/cout/ovf valid, and those results hold until the next
// completion.
interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (output start, sub, a, b, input sum, cout, ovf, busy, done);
  modport slave  (input start, sub, a, b, output sum, cout, ovf, busy, done);
endinterface

// File: rtl/serial_add_rtl.sv
// Bit-serial add/subtract: one 1-bit sum/carry slice plus a carry flop, LSB first,
// one bit per clock, start/busy/done handshake.
module serial_add_rtl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus,
  output logic [1:0]   dbg_state
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;

  logic             s, c_next, accept, last;
  logic [WIDTH-1:0] res_cat;

  assign s       = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  // The newest bit enters at the top; on the final bit this is the whole result.
  assign res_cat = {s, res_q};
  assign accept  = bus.start && (state_q != RUN);
  assign last    = (state_q == RUN) && (cnt_q == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == LAST_BIT) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert b and preload the carry with 1.
      a_q     <= bus.a;
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      res_q   <= res_cat[WIDTH-1:1];
      carry_q <= c_next;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last) begin
        sum_q  <= res_cat;
        cout_q <= c_next;
        ovf_q  <= carry_q ^ c_next;
      end
    end
  end

  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_serial_add_rtl.sv
// Bench for serial_add_rtl: directed vectors plus random operations checked against an
// arithmetic reference model, on an 8-bit and a 16-bit instance.
module tb_serial_add_rtl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_add_if #(.WIDTH(8))  if8 ();
  serial_add_if #(.WIDTH(16)) if16 ();
  logic [1:0] dbg8, dbg16;

  serial_add_rtl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave),  .dbg_state(dbg8));
  serial_add_rtl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave), .dbg_state(dbg16));

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum[15:0]}.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    longint ua, ub, sa, sb, full, sres, mask, half;
    logic   cout, ovf;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (ua >= half) ? ua - (longint'(1) << w) : ua;
    sb = (ub >= half) ? ub - (longint'(1) << w) : ub;
    if (s) begin
      full = (ua - ub) & mask;
      cout = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = (ua + ub) & mask;
      cout = ((ua + ub) > mask);
      sres = sa + sb;
    end
    ovf = (sres >= half) || (sres < -half);
    return {ovf, cout, 16'(full)};
  endfunction

  // Runs one 8-bit operation starting from a cycle where the DUT accepts start.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit noise,
                      input string tag,
                      output logic [7:0] r_sum, output logic r_cout, output logic r_ovf);
    int lat = 0, busy_cnt = 0;
    bit got = 0;
    logic [7:0] prev_sum = if8.sum;
    if8.a = a; if8.b = b; if8.sub = s; if8.start = 1'b1;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) if8.start = 1'b0;
      if (noise && lat >= 2 && lat <= 4) begin
        if8.start = (lat <= 3);
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.sub = 1'($urandom);
      end
      if (if8.busy) busy_cnt++;
      if (if8.done) got = 1;
      else begin
        n_cmp++;
        if (if8.sum !== prev_sum) begin
          n_err++; $display("FAIL %s_sum_stable: got %h want %h (cycle %0d)", tag, if8.sum, prev_sum, lat);
        end
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL %s_timeout: no done within %0d cycles", tag, lat);
    end
    n_cmp++;
    if (lat !== 9) begin
      n_err++; $display("FAIL %s_latency: got %0d want 9", tag, lat);
    end
    n_cmp++;
    if (busy_cnt !== 8) begin
      n_err++; $display("FAIL %s_busy_cycles: got %0d want 8", tag, busy_cnt);
    end
    r_sum = if8.sum; r_cout = if8.cout; r_ovf = if8.ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if8.start = 0; if8.sub = 0; if8.a = 0; if8.b = 0;
    if16.start = 0; if16.sub = 0; if16.a = 0; if16.b = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({if8.sum, if8.cout, if8.ovf, if8.busy, if8.done} !== 12'h0) begin
      n_err++; $display("FAIL reset8: got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
                        if8.sum, if8.cout, if8.ovf, if8.busy, if8.done);
    end
    n_cmp++;
    if ({if16.sum, if16.cout, if16.ovf, if16.busy, if16.done} !== 20'h0) begin
      n_err++; $display("FAIL reset16: got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
                        if16.sum, if16.cout, if16.ovf, if16.busy, if16.done);
    end
  endtask

  task automatic test_directed();
    logic [7:0] a_v[4] = '{8'h5A, 8'hFF, 8'h10, 8'h80};
    logic [7:0] b_v[4] = '{8'h3C, 8'h01, 8'h20, 8'h01};
    logic       s_v[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] e_v[4] = '{{1'b1, 1'b0, 8'h96}, {1'b0, 1'b1, 8'h00},
                           {1'b0, 1'b0, 8'hF0}, {1'b1, 1'b1, 8'h7F}};
    logic [7:0] r_sum;
    logic       r_cout, r_ovf;
    for (int i = 0; i < 4; i++) begin
      run8(a_v[i], b_v[i], s_v[i], 0, $sformatf("dir%0d", i), r_sum, r_cout, r_ovf);
      n_cmp++;
      if ({r_ovf, r_cout, r_sum} !== e_v[i]) begin
        n_err++; $display("FAIL dir%0d_result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                          i, r_ovf, r_cout, r_sum, e_v[i][9], e_v[i][8], e_v[i][7:0]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (if8.done !== 1'b0) begin
        n_err++; $display("FAIL dir%0d_done_pulse: got done=%b want 0", i, if8.done);
      end
    end
  endtask

  task automatic test_ignore_midrun();
    logic [7:0] r_sum;
    logic       r_cout, r_ovf;
    int         extra = 0;
    run8(8'h80, 8'h01, 1'b1, 1, "noise", r_sum, r_cout, r_ovf);
    if8.start = 1'b0;
    n_cmp++;
    if ({r_ovf, r_cout, r_sum} !== {1'b1, 1'b1, 8'h7F}) begin
      n_err++; $display("FAIL noise_result: got ovf=%b cout=%b sum=%h want ovf=1 cout=1 sum=7f",
                        r_ovf, r_cout, r_sum);
    end
    repeat (12) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) extra++;
    end
    n_cmp++;
    if (extra !== 0) begin
      n_err++; $display("FAIL noise_single_op: got %0d extra busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r_sum, first_sum;
    logic       r_cout, r_ovf;
    int         n = 0;
    bit         got = 0;
    run8(8'h5A, 8'h3C, 1'b0, 0, "b2b_first", r_sum, r_cout, r_ovf);
    first_sum = r_sum;
    if8.a = 8'h03; if8.b = 8'h04; if8.sub = 1'b0; if8.start = 1'b1;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        if8.start = 1'b0;
        n_cmp++;
        if ({if8.busy, if8.done} !== 2'b10) begin
          n_err++; $display("FAIL b2b_restart: got busy=%b done=%b want busy=1 done=0", if8.busy, if8.done);
        end
      end
      if (if8.done) got = 1;
      else begin
        n_cmp++;
        if (if8.sum !== first_sum) begin
          n_err++; $display("FAIL b2b_hold: got %h want %h (cycle %0d)", if8.sum, first_sum, n);
        end
      end
    end
    n_cmp++;
    if (n !== 9 || !got) begin
      n_err++; $display("FAIL b2b_spacing: got %0d cycles (done=%b) want 9", n, got);
    end
    n_cmp++;
    if ({if8.ovf, if8.cout, if8.sum} !== {1'b0, 1'b0, 8'h07}) begin
      n_err++; $display("FAIL b2b_result: got ovf=%b cout=%b sum=%h want ovf=0 cout=0 sum=07",
                        if8.ovf, if8.cout, if8.sum);
    end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] r_sum;
    logic       r_cout, r_ovf;
    int         dones = 0;
    if8.a = 8'hFF; if8.b = 8'hFF; if8.sub = 1'b0; if8.start = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if8.start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({if8.sum, if8.cout, if8.ovf, if8.busy, if8.done} !== 12'h0) begin
      n_err++; $display("FAIL rst_mid: got sum=%h cout=%b ovf=%b busy=%b done=%b want all 0",
                        if8.sum, if8.cout, if8.ovf, if8.busy, if8.done);
    end
    repeat (12) begin
      @(posedge clk); #1;
      if (if8.done || if8.busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++; $display("FAIL rst_no_done: got %0d busy/done cycles want 0", dones);
    end
    run8(8'h01, 8'h01, 1'b0, 0, "rst_after", r_sum, r_cout, r_ovf);
    n_cmp++;
    if ({r_ovf, r_cout, r_sum} !== {1'b0, 1'b0, 8'h02}) begin
      n_err++; $display("FAIL rst_after_result: got ovf=%b cout=%b sum=%h want ovf=0 cout=0 sum=02",
                        r_ovf, r_cout, r_sum);
    end
  endtask

  task automatic test_random8();
    logic [7:0]  a, b, r_sum;
    logic        s, r_cout, r_ovf;
    logic [17:0] e;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      if (i < 4) begin
        a = (i[0]) ? 8'h80 : 8'h7F;
        b = (i[1]) ? 8'hFF : 8'h80;
      end
      e = model(8, {8'h0, a}, {8'h0, b}, s);
      run8(a, b, s, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i), r_sum, r_cout, r_ovf);
      if8.start = 1'b0;
      n_cmp++;
      if ({r_ovf, r_cout, r_sum} !== {e[17], e[16], e[7:0]}) begin
        n_err++; $display("FAIL rnd%0d_result: a=%h b=%h sub=%b got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                          i, a, b, s, r_ovf, r_cout, r_sum, e[17], e[16], e[7:0]);
      end
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_width16();
    logic [15:0] a, b;
    logic        s;
    logic [17:0] e;
    int          lat;
    bit          got;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        a = 16'h7FFF; b = 16'h0001; s = 1'b0;
        e = {1'b1, 1'b0, 16'h8000};
      end else begin
        a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
        e = model(16, a, b, s);
      end
      if16.a = a; if16.b = b; if16.sub = s; if16.start = 1'b1;
      lat = 0; got = 0;
      while (!got && lat < 60) begin
        @(posedge clk); #1;
        lat++;
        if16.start = 1'b0;
        if (if16.done) got = 1;
      end
      n_cmp++;
      if (lat !== 17 || !got) begin
        n_err++; $display("FAIL w16_%0d_latency: got %0d (done=%b) want 17", i, lat, got);
      end
      n_cmp++;
      if ({if16.ovf, if16.cout, if16.sum} !== e) begin
        n_err++; $display("FAIL w16_%0d_result: a=%h b=%h sub=%b got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                          i, a, b, s, if16.ovf, if16.cout, if16.sum, e[17], e[16], e[15:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_midrun();
    test_back_to_back();
    @(posedge clk); #1;
    test_reset_midrun();
    @(posedge clk); #1;
    test_random8();
    test_width16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
